// File: rtl/bus_fetch_sequencer_pkg.sv
// Shared types and encodings for the instruction-fetch bus sequencer.
//   seq_state_t : FSM state encoding; the numeric value is exported on state_dbg
//   PC_*        : PCMUX select encodings
package seq_pkg;

  typedef enum logic [2:0] {
    HALT  = 3'd0,
    F1    = 3'd1,
    F2    = 3'd2,
    F3    = 3'd3,
    EXEC  = 3'd4,
    PAUSE = 3'd5
  } seq_state_t;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_BUS  = 2'b01;
  localparam logic [1:0] PC_ADDR = 2'b10;

endpackage

// File: rtl/bus_fetch_sequencer_rise_detect.sv
// 1-bit rising-edge detector with a registered history bit.
//   clk   in  : rising-edge clock
//   reset in  : synchronous active-high reset, clears the history bit
//   d     in  : level to watch
//   rise  out : d is 1 now and was 0 on the previous clock
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/bus_fetch_sequencer.sv
// Moore FSM sequencing the shared 16-bit bus through the fetch phases
// (MAR<-PC, MDR<-M[MAR], IR<-MDR), then handing bus and loads to the execute
// unit until it reports completion. Supports PAUSE with resume on a Continue rise.
//   Clk, Reset              : clock, synchronous active-high reset
//   Run                     : start fetching (HALT only)
//   Continue                : resume from PAUSE on a 0->1 edge
//   ex_done, pause_req      : execute-unit completion and pause flag (EXEC only)
//   Gate{ALU,PC,MARMUX,MDR} : one-hot bus gate selects
//   LD_{MAR,MDR,IR,PC}      : register load enables
//   PCMUX_sel, mem_rd       : PC mux select, memory read strobe
//   ex_grant                : execute unit owns the bus
//   state_dbg               : encoded current state
//
// state | meaning
// HALT  | idle, waiting for Run
// F1    | MAR<-PC, PC<-PC+1
// F2    | memory read, MEM_WAIT cycles; LD_MDR on the last one
// F3    | IR<-MDR
// EXEC  | execute unit owns the bus until ex_done
// PAUSE | idle until a Continue rise
module bus_fetch_sequencer #(
  parameter int         MEM_WAIT = 2,
  parameter logic [1:0] PC_INC   = 2'b00
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic       ex_done,
  input  logic       pause_req,
  output logic       GateALU,
  output logic       GatePC,
  output logic       GateMARMUX,
  output logic       GateMDR,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_PC,
  output logic [1:0] PCMUX_sel,
  output logic       mem_rd,
  output logic       ex_grant,
  output logic [2:0] state_dbg
);

  import seq_pkg::seq_state_t;
  import seq_pkg::HALT;
  import seq_pkg::F1;
  import seq_pkg::F2;
  import seq_pkg::F3;
  import seq_pkg::EXEC;
  import seq_pkg::PAUSE;

  localparam int                CNT_W    = $clog2(MEM_WAIT + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(MEM_WAIT - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             cont_rise;

  rise_detect u_cont_rise (
    .clk   (Clk),
    .reset (Reset),
    .d     (Continue),
    .rise  (cont_rise)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= HALT;
      wait_cnt <= '0;
    end else begin
      case (state)
        HALT:  if (Run) state <= F1;
        F1: begin
          state    <= F2;
          wait_cnt <= CNT_INIT;
        end
        // wait_cnt counts the remaining F2 cycles after this one
        F2: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
          else                state    <= F3;
        end
        F3:    state <= EXEC;
        EXEC:  if (ex_done) state <= pause_req ? PAUSE : F1;
        PAUSE: if (cont_rise) state <= F1;
        default: state <= HALT;
      endcase
    end
  end

  // GateALU/GateMARMUX stay low here: the execute unit drives those while
  // it holds ex_grant.
  always_comb begin
    GateALU    = 1'b0;
    GatePC     = 1'b0;
    GateMARMUX = 1'b0;
    GateMDR    = 1'b0;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_PC      = 1'b0;
    PCMUX_sel  = 2'b00;
    mem_rd     = 1'b0;
    ex_grant   = 1'b0;
    case (state)
      F1: begin
        GatePC    = 1'b1;
        LD_MAR    = 1'b1;
        LD_PC     = 1'b1;
        PCMUX_sel = PC_INC;
      end
      F2: begin
        mem_rd = 1'b1;
        LD_MDR = (wait_cnt == '0);
      end
      F3: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      EXEC:    ex_grant = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule
